// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the mips byte bus.
// The processor pushes bytes into a small TX FIFO through TXDATA. The serialiser
// drains the FIFO onto tx, LSB first, with one start bit and one stop bit.
// Register map at BASE: +0 TXDATA (W), +1 STATUS (R), +2 CTRL (R/W), +3 reserved.
module mmio_uart_tx #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] BASE         = 8'hF0,
    parameter int               CLKS_PER_BIT = 16,
    parameter int               DEPTH        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] rdata,
    output logic             rsel,
    output logic             tx
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Register state
    logic [1:0]        state_q,   state_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [WIDTH-1:0]  shift_q,   shift_d;
    logic              tx_q,      tx_d;
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic              ovf_q,     ovf_d;
    logic              enable_q,  enable_d;
    logic              rsel_q,    rsel_d;
    logic [WIDTH-1:0]  rdata_q,   rdata_d;

    logic [WIDTH-1:0]  fifo_mem [DEPTH];

    // Bus decode
    logic       hit;
    logic [1:0] off;
    logic       wr_txdata, wr_ctrl, flush;
    logic       full, empty, busy;
    logic       push, pop;
    logic [WIDTH-1:0] status_val, ctrl_val;

    assign hit       = (adr[WIDTH-1:2] == BASE[WIDTH-1:2]);
    assign off       = adr[1:0];
    assign wr_txdata = memwrite && hit && (off == 2'd0);
    assign wr_ctrl   = memwrite && hit && (off == 2'd2);
    assign flush     = wr_ctrl && writedata[1];

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign busy  = (state_q != S_IDLE);

    // A push into a full FIFO is dropped even if the serialiser pops that cycle.
    assign push = wr_txdata && !full;
    assign pop  = (state_q == S_IDLE) && enable_q && !empty;

    assign status_val = {{(WIDTH-4){1'b0}}, ovf_q, busy, empty, full};
    assign ctrl_val   = {{(WIDTH-1){1'b0}}, enable_q};

    // Next-state logic for the FIFO bookkeeping, register file, read port and serialiser.
    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case/if tree leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        enable_d   = enable_q;
        rsel_d     = 1'b0;
        rdata_d    = '0;

        // Reads sample the registers before any same-cycle write lands.
        if (memread && hit) begin
            rsel_d = 1'b1;
            case (off)
                2'd1:    rdata_d = status_val;
                2'd2:    rdata_d = ctrl_val;
                default: rdata_d = '0;
            endcase
        end

        if (wr_txdata && full) ovf_d = 1'b1;
        if (wr_ctrl) enable_d = writedata[0];

        // Pointers wrap naturally because DEPTH is a power of two.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Serialiser: tx_d is the line level for the cycle after this edge.
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d    = fifo_mem[rd_ptr_q];
                    baud_cnt_d = '0;
                    tx_d       = 1'b0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    tx_d       = shift_q[0];
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == IDX_LAST) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; a reset mid-frame drops the line high at once.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            enable_q   <= 1'b1;
            rsel_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            enable_q   <= enable_d;
            rsel_q     <= rsel_d;
            rdata_q    <= rdata_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; count/pointers define which
        // entries are valid, so clearing the data would only cost logic.
        if (push) fifo_mem[wr_ptr_q] <= writedata;
    end

    assign tx    = tx_q;
    assign rsel  = rsel_q;
    assign rdata = rdata_q;

endmodule
